// File: rtl/sha2_pad_ctrl_if.sv
// Handshake, select and status bundle between the SHA-2 pad controller and its neighbours.
// slave = controller side; master = the upstream/downstream environment.
interface sha2_pad_ctrl_if #(
  parameter int W    = 64,
  parameter int PKTS = 8
);
  localparam int IW = $clog2(PKTS);

  logic          in_valid;
  logic          in_last;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic          pad_pkt;
  logic          zero_pkt;
  logic          mgln_pkt;
  logic [W-1:0]  msg_len;
  logic [IW-1:0] pkt_idx;
  logic          blk_last;
  logic          msg_done;

  modport slave (
    input  in_valid, in_last, out_ready,
    output in_ready, out_valid, pad_pkt, zero_pkt, mgln_pkt,
           msg_len, pkt_idx, blk_last, msg_done
  );

  modport master (
    output in_valid, in_last, out_ready,
    input  in_ready, out_valid, pad_pkt, zero_pkt, mgln_pkt,
           msg_len, pkt_idx, blk_last, msg_done
  );
endinterface

// File: rtl/sha2_pad_ctrl.sv
// Sequences data, pad, zero and length packets into pktmux so every block is correctly padded.
// Handshake: a packet moves on out_valid & out_ready; a data packet is taken on in_valid & in_ready.
module sha2_pad_ctrl #(
  parameter int W    = 64,
  parameter int PKTS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  sha2_pad_ctrl_if.slave       bus,
  output logic [1:0]           state
);
  localparam int IW = $clog2(PKTS);
  localparam logic [IW-1:0] LAST_IDX = IW'(PKTS - 1);
  localparam logic [W-1:0]  LEN_STEP = W'(W);

  typedef enum logic [1:0] {
    ST_DATA = 2'd0,
    ST_PAD  = 2'd1,
    ST_ZERO = 2'd2,
    ST_LEN  = 2'd3
  } state_t;

  state_t        cur;
  state_t        nxt;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_inc;
  logic [W-1:0]  len;
  logic          done;
  logic          step;

  assign idx_inc = (idx == LAST_IDX) ? '0 : idx + 1'b1;

  always_comb begin
    nxt           = cur;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    step          = 1'b0;
    case (cur)
      ST_DATA: begin
        bus.in_ready  = bus.out_ready;
        bus.out_valid = bus.in_valid;
        step          = bus.in_valid & bus.out_ready;
        if (step && bus.in_last) nxt = ST_PAD;
      end
      ST_PAD: begin
        bus.out_valid = 1'b1;
        step          = bus.out_ready;
        if (step) nxt = (idx_inc == LAST_IDX) ? ST_LEN : ST_ZERO;
      end
      ST_ZERO: begin
        bus.out_valid = 1'b1;
        step          = bus.out_ready;
        if (step && idx_inc == LAST_IDX) nxt = ST_LEN;
      end
      ST_LEN: begin
        bus.out_valid = 1'b1;
        step          = bus.out_ready;
        if (step) nxt = ST_DATA;
      end
      default: nxt = ST_DATA;
    endcase
  end

  // Length counts accepted data packets only; pad/zero/len packets advance the index alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur  <= ST_DATA;
      idx  <= '0;
      len  <= '0;
      done <= 1'b0;
    end else begin
      cur  <= nxt;
      done <= (cur == ST_LEN) && step;
      if (step) begin
        if (cur == ST_LEN) begin
          idx <= '0;
          len <= '0;
        end else begin
          idx <= idx_inc;
          if (cur == ST_DATA) len <= len + LEN_STEP;
        end
      end
    end
  end

  assign bus.pad_pkt  = (cur == ST_PAD);
  assign bus.zero_pkt = (cur == ST_ZERO);
  assign bus.mgln_pkt = (cur == ST_LEN);
  assign bus.blk_last = (idx == LAST_IDX);
  assign bus.msg_len  = len;
  assign bus.pkt_idx  = idx;
  assign bus.msg_done = done;
  assign state        = cur;
endmodule

// File: tb/tb_sha2_pad_ctrl.sv
// Scoreboard bench for sha2_pad_ctrl: driver pushes expected packets, a negedge monitor pops and compares.
module tb_sha2_pad_ctrl;
  localparam int W    = 64;
  localparam int PKTS = 8;
  localparam int IW   = $clog2(PKTS);
  localparam int EW   = 3 + IW + 1 + W;

  logic       clk;
  logic       rst;
  logic [1:0] state;
  int         errors;
  int         checks;
  int         xfer_cnt;
  int         blk_cnt;
  bit         stall;
  bit         start_on_done;
  bit         exp_done;

  logic [EW-1:0] exp_q[$];

  sha2_pad_ctrl_if #(.W(W), .PKTS(PKTS)) bus ();

  sha2_pad_ctrl #(.W(W), .PKTS(PKTS)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus.slave),
    .state (state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_pkt(input logic [2:0] sel, input int ix, input logic [W-1:0] ln);
    logic [IW-1:0] i;
    i = IW'(ix);
    exp_q.push_back({sel, i, (ix == PKTS - 1), ln});
  endtask

  // expected sequence for an n-packet message: data, pad, zeros up to idx 6, length at idx 7
  task automatic push_msg(input int n);
    int p;
    for (int i = 0; i < n; i++) push_pkt(3'b000, i % PKTS, W'(64 * i));
    p = n % PKTS;
    push_pkt(3'b100, p, W'(64 * n));
    p = (p + 1) % PKTS;
    while (p != PKTS - 1) begin
      push_pkt(3'b010, p, W'(64 * n));
      p++;
    end
    push_pkt(3'b001, PKTS - 1, W'(64 * n));
  endtask

  // driver: returns at posedge+1 after the last data packet was accepted
  task automatic send_msg(input int n);
    bit acc;
    int budget;
    push_msg(n);
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_last  = (i == n - 1);
      acc = 1'b0;
      budget = 0;
      while (!acc && budget < 400) begin
        @(negedge clk);
        acc = bus.in_ready;
        @(posedge clk);
        #1;
        budget++;
      end
      if (!acc) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: got none expected accept of packet %0d", i);
      end
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 400) begin
      @(negedge clk);
      budget++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  // out_ready driver
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [EW-1:0] head;
    logic [EW-1:0] act;
    bit head_data;
    bit nd;
    if (rst) begin
      exp_done = 1'b0;
    end else begin
      nd = 1'b0;
      chk("msg_done", bus.msg_done, exp_done);
      head_data = 1'b1;
      if (exp_q.size() != 0) begin
        head = exp_q[0];
        head_data = (head[EW-1 -: 3] == 3'b000);
      end
      chk("in_ready", bus.in_ready, head_data ? bus.out_ready : 1'b0);
      chk("out_valid", bus.out_valid, head_data ? bus.in_valid : 1'b1);
      if (start_on_done && exp_done) begin
        chk("start_on_done", {bus.out_valid & bus.out_ready, bus.pad_pkt, bus.zero_pkt,
            bus.mgln_pkt, bus.pkt_idx}, {1'b1, 3'b000, {IW{1'b0}}});
        start_on_done = 1'b0;
      end
      if (bus.out_valid && bus.out_ready) begin
        xfer_cnt++;
        if (bus.blk_last) blk_cnt++;
        act = {bus.pad_pkt, bus.zero_pkt, bus.mgln_pkt, bus.pkt_idx, bus.blk_last, bus.msg_len};
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pkt: got %0h expected no transfer", act);
        end else begin
          head = exp_q.pop_front();
          chk("packet", act, head);
          nd = (head[EW-1 -: 3] == 3'b001);
        end
      end
      exp_done = nd;
    end
  end

  initial begin
    int x0;
    int b0;
    errors = 0;
    checks = 0;
    xfer_cnt = 0;
    blk_cnt = 0;
    stall = 1'b0;
    start_on_done = 1'b0;
    exp_done = 1'b0;
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_last  = 1'b0;
    #3;
    chk("rst_state", state, 2'd0);
    chk("rst_idx", bus.pkt_idx, 0);
    chk("rst_len", bus.msg_len, 0);
    chk("rst_sel", {bus.pad_pkt, bus.zero_pkt, bus.mgln_pkt, bus.blk_last, bus.msg_done}, 0);
    chk("rst_out_valid", bus.out_valid, 1'b1);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 1-packet message
    x0 = xfer_cnt; b0 = blk_cnt;
    send_msg(1);
    wait_idle();
    chk("m1_xfers", xfer_cnt - x0, 8);
    chk("m1_blk_last", blk_cnt - b0, 1);

    // 6-packet message: no zero packet
    x0 = xfer_cnt; b0 = blk_cnt;
    send_msg(6);
    wait_idle();
    chk("m6_xfers", xfer_cnt - x0, 8);
    chk("m6_blk_last", blk_cnt - b0, 1);

    // 7-packet message: padding spills into a second block
    x0 = xfer_cnt; b0 = blk_cnt;
    send_msg(7);
    wait_idle();
    chk("m7_xfers", xfer_cnt - x0, 16);
    chk("m7_blk_last", blk_cnt - b0, 2);

    // 8-packet message under random stalls, next message held during padding
    x0 = xfer_cnt;
    stall = 1'b1;
    send_msg(8);
    send_msg(1);
    wait_idle();
    stall = 1'b0;
    chk("stall_xfers", xfer_cnt - x0, 24);

    // back-to-back 1-packet messages
    x0 = xfer_cnt;
    @(posedge clk);
    #1;
    send_msg(1);
    start_on_done = 1'b1;
    send_msg(1);
    wait_idle();
    chk("b2b_xfers", xfer_cnt - x0, 16);
    chk("b2b_start_seen", start_on_done, 1'b0);

    // reset pulsed mid-ZERO
    send_msg(1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("pre_rst_zero", {bus.zero_pkt, bus.pkt_idx}, {1'b1, IW'(2)});
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("mid_rst_state", state, 2'd0);
    chk("mid_rst_idx", bus.pkt_idx, 0);
    chk("mid_rst_len", bus.msg_len, 0);
    chk("mid_rst_sel", {bus.pad_pkt, bus.zero_pkt, bus.mgln_pkt, bus.blk_last, bus.msg_done}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    x0 = xfer_cnt;
    send_msg(1);
    wait_idle();
    chk("post_rst_xfers", xfer_cnt - x0, 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sha2_pad_ctrl.md
# sha2_pad_ctrl

Sequencing controller for the SHA-2 input processing unit. It sits directly upstream of `pktmux` and drives that block's `pad_pkt`, `zero_pkt`, `mgln_pkt` selects and its `msg_len` operand. It passes message packets through, then appends the padding packet, the zero packets and the length packet, so that every 512-bit block (8 × 64-bit packets) handed downstream is correctly padded. It also counts the message length in bits and marks block and message boundaries for the compression core.

## Interface
- `W`, 64, packet width in bits; also the width of the length counter.
- `PKTS`, 8, packets per block; the length packet always occupies index `PKTS-1`.
- `clk` input 1 — single clock, rising edge.
- `rst` input 1 — asynchronous, active-high reset.
- `in_valid` input 1 — upstream packet available.
- `in_last` input 1 — qualifies `in_valid`; the current packet is the final data packet of the message.
- `in_ready` output 1 — controller accepts a data packet this cycle.
- `out_valid` output 1 — a packet (data, pad, zero or length) is presented to `pktmux`.
- `out_ready` input 1 — downstream consumes the packet this cycle.
- `pad_pkt`, `zero_pkt`, `mgln_pkt` output 1 each — `pktmux` selects; at most one is high; all low = pass data.
- `msg_len` output W — message length in bits, fed to `pktmux.msg_len`.
- `pkt_idx` output log2(PKTS) — index of the presented packet within its block.
- `blk_last` output 1 — presented packet is index `PKTS-1`.
- `msg_done` output 1 — one-cycle pulse after the length packet transfers.

## Operation
- Transfer on the output side = `out_valid & out_ready`. Accept on the input side = `in_valid & in_ready`.
- FSM states: DATA, PAD, ZERO, LEN. Selects are Moore outputs decoded from the state:
  - DATA: all low.
  - PAD: `pad_pkt`.
  - ZERO: `zero_pkt`.
  - LEN: `mgln_pkt`.
- **DATA**
  - `in_ready = out_ready`; `out_valid = in_valid`.
  - On accept: `pkt_idx` ← `pkt_idx+1` mod PKTS; `msg_len` ← `msg_len + W`.
  - If `in_last` is high on accept: go to PAD.
- **PAD**
  - `in_ready = 0`; `out_valid = 1`.
  - On transfer: `pkt_idx` advances. Go to LEN if the new index is `PKTS-1`, otherwise go to ZERO.
- **ZERO**
  - `out_valid = 1`.
  - On transfer: `pkt_idx` advances. Go to LEN when the new index is `PKTS-1`.
- **LEN**
  - `out_valid = 1`; `msg_len` holds its final value.
  - On transfer: go to DATA; `pkt_idx` ← 0; `msg_len` ← 0; `msg_done` ← 1 for the next cycle.
- Boundary cases by index of the last data packet:
  - Index 5 (`PKTS-3`): PAD at 6, LEN at 7; no ZERO.
  - Index 6 (`PKTS-2`): PAD at 7, then ZERO at 0..6 of a new block, then LEN at 7.
  - Index 7 (`PKTS-1`): PAD at 0 of a new block, ZERO at 1..6, LEN at 7.
- `msg_len` wraps modulo 2^W; no overflow flag.
- Zero-length messages are not supported: `in_last` must accompany a real data packet.
- `in_last` without `in_valid` is ignored.
- `in_valid` while in PAD, ZERO or LEN is held off (`in_ready = 0`); the packet is not lost.

## Timing
- Reset values:
  - State = DATA, `pkt_idx` = 0, `msg_len` = 0, `msg_done` = 0.
  - Selects = 0; `blk_last` = 0.
  - `out_valid` follows `in_valid`; `in_ready` follows `out_ready`.
- DATA pass-through has zero latency: `out_valid` and `in_ready` are combinational from the handshake inputs.
- Selects, `pkt_idx`, `blk_last` and `msg_len` are registered or decoded from registers only, so they are stable for the whole cycle.
- Padding adds no bubbles. PAD follows the last data accept on the next cycle, and each subsequent packet follows the previous transfer by one cycle when `out_ready` = 1.
- With `out_ready` = 0, the state, selects, `pkt_idx` and `msg_len` hold.
- A new message may start in DATA on the cycle `msg_done` is high.
- `rst` asserted at any point, including mid-padding, forces the reset values immediately. Any partially emitted block is abandoned.

## Test plan
- 1-packet message, `out_ready` = 1 → data at idx 0, PAD at idx 1, ZERO at idx 2..6, LEN at idx 7 with `msg_len` = 64, `msg_done` pulse; 8 transfers total.
- 6-packet message → data idx 0..5, PAD idx 6, LEN idx 7 with `msg_len` = 384, no ZERO packet, `blk_last` only on LEN.
- 7-packet message → PAD idx 7 of block 0, ZERO idx 0..6 of block 1, LEN idx 7 with `msg_len` = 448; 16 transfers total, `blk_last` twice.
- Random `out_ready` stalls on an 8-packet message → state and outputs hold during stalls, packet order is unchanged, LEN = 512, and `in_valid` held high during padding is not accepted until DATA.
- Back-to-back 1-packet messages → second message's data appears at idx 0 on the cycle `msg_done` pulses, and its length packet carries 64, not 128.
- `rst` pulsed while in ZERO → next cycle state DATA, `pkt_idx` = 0, `msg_len` = 0, selects low; a following 1-packet message pads correctly.
